count_display_driver: RTL and testbench

- Downstream stage of the 5-bit synchronous up/down counter. Consumes its count and mode outputs and drives a 2-digit multiplexed 7-segment display.
- Converts the binary count to BCD with a sequential shift-add-3 (double-dabble) FSM, one bit per cycle.
- Time-multiplexes the units and tens digits with a refresh prescaler.
- Shows the count direction on the units decimal point.

---
 rtl/count_display_pkg.sv | 21 ++
 rtl/count_display_driver_seg7_decode.sv | 26 ++
 rtl/count_display_driver.sv | 148 ++++++++++++++
 tb/tb_count_display_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// Shared types and constants for the count display driver.
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.
package count_display_pkg;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam int unsigned BCD_DIGITS = 2;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/count_display_driver_seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment pattern.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_driver.sv
// Converts the counter value to BCD one bit per cycle (double-dabble) and
// drives a 2-digit multiplexed 7-segment display with a direction dot.
module count_display_driver
  import count_display_pkg::*;
#(
  parameter int unsigned WIDTH          = 5,
  parameter int unsigned REFRESH_DIV    = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [1:0]       an,
  output logic [7:0]       bcd,
  output logic             busy
);

  localparam int unsigned SrW = 4 * BCD_DIGITS + WIDTH;
  localparam int unsigned PsW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_e           state_q, state_d;
  logic [SrW-1:0]   sr_q, sr_d, sr_adj, sr_step;
  logic [2:0]       iter_q, iter_d;
  logic [7:0]       bcd_q, bcd_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             force_q, force_d;
  logic [WIDTH-1:0] last_count_q, last_count_d;
  logic [PsW-1:0]   prescaler_q, prescaler_d;
  logic             digit_sel_q, digit_sel_d;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sr_q[WIDTH + 4 * i +: 4] >= 4'd5) begin
        sr_adj[WIDTH + 4 * i +: 4] = sr_q[WIDTH + 4 * i +: 4] + 4'd3;
      end
    end
    sr_step = sr_adj << 1;
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    iter_d       = iter_q;
    bcd_d        = bcd_q;
    busy_d       = busy_q;
    valid_d      = valid_q;
    force_d      = force_q;
    last_count_d = last_count_q;
    unique case (state_q)
      StIdle: begin
        if (force_q || (count != last_count_q)) begin
          sr_d         = {{(4 * BCD_DIGITS){1'b0}}, count};
          last_count_d = count;
          force_d      = 1'b0;
          iter_d       = 3'd0;
          busy_d       = 1'b1;
          state_d      = StShift;
        end
      end
      StShift: begin
        sr_d   = sr_step;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'(WIDTH - 1)) begin
          bcd_d   = sr_step[WIDTH +: 8];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prescaler_d = prescaler_q + PsW'(1);
    digit_sel_d = digit_sel_q;
    if (prescaler_q == PsW'(REFRESH_DIV - 1)) begin
      prescaler_d = '0;
      digit_sel_d = ~digit_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      sr_q         <= '0;
      iter_q       <= 3'd0;
      bcd_q        <= 8'h00;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      force_q      <= 1'b1;
      last_count_q <= '0;
      prescaler_q  <= '0;
      digit_sel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      iter_q       <= iter_d;
      bcd_q        <= bcd_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      force_q      <= force_d;
      last_count_q <= last_count_d;
      prescaler_q  <= prescaler_d;
      digit_sel_q  <= digit_sel_d;
    end
  end

  logic [3:0] nibble;
  logic [6:0] seg_dec, seg_raw;
  logic       dp_raw;

  assign nibble = digit_sel_q ? bcd_q[7:4] : bcd_q[3:0];

  seg7_decode u_seg7_decode (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_comb begin
    an      = 2'b00;
    seg_raw = SEG_BLANK;
    dp_raw  = 1'b0;
    if (valid_q) begin
      if (!digit_sel_q) begin
        an      = 2'b01;
        seg_raw = seg_dec;
        dp_raw  = mode;
      end else begin
        an      = 2'b10;
        // Leading-zero blanking on the tens digit.
        seg_raw = (bcd_q[7:4] == 4'd0) ? SEG_BLANK : seg_dec;
      end
    end
    seg = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dp  = SEG_ACTIVE_LOW ? ~dp_raw : dp_raw;
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: a cycle model built from
// arithmetic (decimal split, timers) plus directed literal checks.
module tb_count_display_driver;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned RD    = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] count;
  logic             mode;
  logic [6:0]       seg, seg_n;
  logic             dp, dp_n;
  logic [1:0]       an, an_n;
  logic [7:0]       bcd, bcd_n;
  logic             busy, busy_n;

  int n_checks = 0;
  int n_fail   = 0;

  count_display_driver #(
    .WIDTH          (WIDTH),
    .REFRESH_DIV    (RD),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .mode  (mode),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .bcd   (bcd),
    .busy  (busy)
  );

  count_display_driver #(
    .WIDTH          (WIDTH),
    .REFRESH_DIV    (RD),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut_n (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .mode  (mode),
    .seg   (seg_n),
    .dp    (dp_n),
    .an    (an_n),
    .bcd   (bcd_n),
    .busy  (busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model: conversion takes WIDTH+1 edges from load; display slot follows
  // the number of edges since reset.
  bit m_known = 0;
  int m_cycles, m_rem, m_cap, m_last, m_bcd;
  bit m_valid, m_force;

  always @(posedge clk) begin
    if (!reset) begin
      m_known = 1; m_cycles = 0; m_rem = 0; m_valid = 0;
      m_bcd = 0; m_force = 1; m_last = 0;
    end else if (m_known) begin
      m_cycles++;
      if (m_rem == 0) begin
        if (m_force || int'(count) != m_last) begin
          m_cap = int'(count); m_last = int'(count); m_force = 0; m_rem = WIDTH;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_bcd   = ((m_cap / 10) << 4) | (m_cap % 10);
          m_valid = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int busy_run = 0;

  always @(negedge clk) begin
    if (m_known) begin
      logic [1:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      int         sel;
      sel   = (m_cycles / RD) % 2;
      e_an  = 2'b00; e_seg = 7'h00; e_dp = 1'b0;
      if (m_valid) begin
        if (sel == 0) begin
          e_an = 2'b01; e_seg = seg_tab[m_bcd % 16]; e_dp = mode;
        end else begin
          e_an  = 2'b10;
          e_seg = ((m_bcd / 16) == 0) ? 7'h00 : seg_tab[m_bcd / 16];
        end
      end
      chk("cycle_model", {16'h0, an, seg, dp, bcd, busy},
          {16'h0, e_an, e_seg, e_dp, m_bcd[7:0], (m_rem != 0)});
      chk("cycle_model_inv", {16'h0, an_n, seg_n, dp_n, bcd_n, busy_n},
          {16'h0, e_an, ~e_seg, ~e_dp, m_bcd[7:0], (m_rem != 0)});
      if (busy) busy_run++;
      else if (busy_run > 0) begin
        chk("busy_len_ok", 32'(busy_run <= WIDTH + 1), 32'd1);
        busy_run = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_an(input logic [1:0] target);
    bit found = 0;
    for (int i = 0; i < 2 * RD + 2; i++) begin
      if (an == target) begin
        found = 1;
        break;
      end
      step(1);
    end
    chk("wait_an", {31'h0, found}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; count = '0; mode = 1'b1;
    step(2);
    chk("rst_an", 32'(an), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h00);
    reset = 1'b1;
    step(1);
    chk("load_busy", 32'(busy), 32'd1);
    step(5);
    chk("first_bcd", 32'(bcd), 32'h00);
    chk("first_idle", 32'(busy), 32'd0);
    wait_an(2'b01);
    chk("zero_units", 32'(seg), 32'h3F);
    wait_an(2'b10);
    chk("zero_tens_blank", 32'(seg), 32'h00);

    count = 5'd23;
    step(6);
    chk("bcd_23", 32'(bcd), 32'h23);
    wait_an(2'b01);
    chk("seg_23_units", 32'(seg), 32'h4F);
    chk("dp_up_units", 32'(dp), 32'd1);
    chk("seg_23_units_inv", 32'(seg_n), 32'h30);
    wait_an(2'b10);
    chk("seg_23_tens", 32'(seg), 32'h5B);
    chk("dp_tens", 32'(dp), 32'd0);

    count = 5'd31;
    step(6);
    chk("bcd_31", 32'(bcd), 32'h31);
    wait_an(2'b10);
    chk("seg_31_tens", 32'(seg), 32'h4F);
    wait_an(2'b01);
    chk("seg_31_units", 32'(seg), 32'h06);

    count = 5'd7;
    step(6);
    chk("bcd_07", 32'(bcd), 32'h07);
    wait_an(2'b10);
    chk("seg_07_tens_blank", 32'(seg), 32'h00);

    mode  = 1'b0;
    count = 5'd12;
    step(2);
    count = 5'd19;
    step(4);
    chk("bcd_12", 32'(bcd), 32'h12);
    step(6);
    chk("bcd_19", 32'(bcd), 32'h19);
    wait_an(2'b01);
    chk("dp_down", 32'(dp), 32'd0);
    chk("dp_down_inv", 32'(dp_n), 32'd1);

    mode  = 1'b1;
    count = 5'd25;
    step(2);
    chk("shift_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    step(1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'h00);
    chk("abort_an", 32'(an), 32'd0);
    reset = 1'b1;
    step(6);
    chk("bcd_25", 32'(bcd), 32'h25);
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
